// File: rtl/ifetch_unit.sv
// Instruction fetch front end: owns the fetch PC, issues in-order
// word reads and buffers returned words with their PCs for decode.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redir,
  input  logic [29:0] redir_pc,
  output logic        imem_req,
  output logic [29:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [29:0] inst_pc,
  output logic [31:0] inst_pcp4
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int AW    = $clog2(DEPTH);

  localparam logic [29:0]    RST_WPC = RESET_PC[31:2];
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(DEPTH);

  logic [29:0]      fetch_pc_q, fetch_pc_d;
  logic [29:0]      rsp_pc_q, rsp_pc_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             post_rst_q;

  logic [29:0]      pc_mem_q   [DEPTH];
  logic [31:0]      inst_mem_q [DEPTH];

  logic [CNT_W:0]   used;
  logic             credit;
  logic             fire_req;
  logic             pop;
  logic             drop;
  logic             push;

  // Credit counts in-flight words too, so the FIFO can never overflow.
  assign used     = {1'b0, out_cnt_q} + {1'b0, fifo_cnt_q};
  assign credit   = used < DEPTH_C;
  assign imem_req = !rst && !post_rst_q && !redir && credit;
  assign fire_req = imem_req && imem_gnt;

  assign imem_addr  = fetch_pc_q;
  assign inst_valid = !rst && (fifo_cnt_q != '0);
  assign pop        = inst_valid && inst_ready;
  assign drop       = imem_rvalid && (drop_cnt_q != '0);
  assign push       = imem_rvalid && !drop && !redir;

  assign inst      = inst_mem_q[rd_ptr_q];
  assign inst_pc   = pc_mem_q[rd_ptr_q];
  assign inst_pcp4 = {inst_pc + 30'd1, 2'b00};

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    out_cnt_d  = out_cnt_q + CNT_W'(fire_req)
               - CNT_W'(imem_rvalid);
    drop_cnt_d = drop_cnt_q;
    fifo_cnt_d = fifo_cnt_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (redir) begin
      fetch_pc_d = redir_pc;
      rsp_pc_d   = redir_pc;
      // Everything still in flight belongs to the old stream.
      drop_cnt_d = out_cnt_q - CNT_W'(imem_rvalid);
      fifo_cnt_d = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
    end else begin
      if (fire_req) fetch_pc_d = fetch_pc_q + 30'd1;
      if (drop)     drop_cnt_d = drop_cnt_q - 1'b1;
      if (push) begin
        rsp_pc_d = rsp_pc_q + 30'd1;
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      fifo_cnt_d = fifo_cnt_q + CNT_W'(push)
                 - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RST_WPC;
      rsp_pc_q   <= RST_WPC;
      out_cnt_q  <= '0;
      drop_cnt_q <= '0;
      fifo_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      post_rst_q <= 1'b1;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      out_cnt_q  <= out_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      fifo_cnt_q <= fifo_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      post_rst_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      pc_mem_q[wr_ptr_q]   <= rsp_pc_q;
      inst_mem_q[wr_ptr_q] <= imem_rdata;
    end
  end

  a_cnt_order: assert property (
    @(posedge clk) disable iff (rst)
    (drop_cnt_q <= out_cnt_q) &&
    ({1'b0, out_cnt_q} <= DEPTH_C)
  );

  a_credit: assert property (
    @(posedge clk) disable iff (rst)
    used <= DEPTH_C
  );

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: in-order memory model plus a
// stream-level model of the expected decode sequence.
module tb_ifetch_unit;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redir = 1'b0;
  logic [29:0] redir_pc = '0;
  logic        imem_req;
  logic [29:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [29:0] inst_pc;
  logic [31:0] inst_pcp4;

  always #5 clk = ~clk;

  ifetch_unit #(
    .RESET_PC(32'h0000_3000),
    .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .redir(redir),
    .redir_pc(redir_pc),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .inst_valid(inst_valid),
    .inst_ready(inst_ready),
    .inst(inst),
    .inst_pc(inst_pc),
    .inst_pcp4(inst_pcp4)
  );

  typedef struct {
    logic [29:0] addr;
    bit          stale;
  } req_t;

  req_t        mq[$];
  int          mfifo;
  logic [29:0] exp_pc;
  logic [29:0] exp_fetch;
  bit          post_rst;

  int checks = 0;
  int errors = 0;

  logic        s_req, s_ival;
  logic [29:0] s_addr, s_ipc;
  bit          g_gnt, g_acc;
  logic [29:0] g_gnt_addr, g_acc_pc;
  logic [31:0] g_acc_pcp4;

  function automatic logic [31:0] memword(input logic [29:0] a);
    return {a, 2'b01} ^ 32'h5A3C_96E1 ^ {2'b00, a[14:0], a[29:15]};
  endfunction

  // One clock: drive inputs, sample, compare with model, advance.
  task automatic step(input bit r, input bit rd,
                      input logic [29:0] rpc, input bit gnt,
                      input bit rv, input bit rdy);
    bit    exp_req, exp_iv;
    req_t  e;
    logic [31:0] exp_p4;
    @(negedge clk);
    rst = r;
    redir = rd;
    redir_pc = rpc;
    imem_gnt = gnt;
    inst_ready = rdy;
    imem_rvalid = rv && !r && (mq.size() > 0);
    imem_rdata = imem_rvalid ? memword(mq[0].addr) : $urandom;
    #1;
    s_req = imem_req;
    s_ival = inst_valid;
    s_addr = imem_addr;
    s_ipc = inst_pc;
    g_gnt = 0;
    g_acc = 0;
    exp_req = !r && !post_rst && !rd && (mq.size() + mfifo < DEPTH);
    exp_iv = !r && (mfifo != 0);
    checks++;
    if (imem_req !== exp_req) begin
      errors++;
      $display("FAIL imem_req: got %b want %b at %0t",
               imem_req, exp_req, $time);
    end
    checks++;
    if (inst_valid !== exp_iv) begin
      errors++;
      $display("FAIL inst_valid: got %b want %b at %0t",
               inst_valid, exp_iv, $time);
    end
    if (r) begin
      mq.delete();
      mfifo = 0;
      exp_pc = 30'h0C00;
      exp_fetch = 30'h0C00;
      post_rst = 1;
      @(posedge clk);
      return;
    end
    post_rst = 0;
    if (inst_valid && rdy) begin
      exp_p4 = {exp_pc + 30'd1, 2'b00};
      checks++;
      if ({inst_pc, inst, inst_pcp4} !==
          {exp_pc, memword(exp_pc), exp_p4}) begin
        errors++;
        $display("FAIL head: got pc %h inst %h p4 %h want pc %h inst %h p4 %h",
                 inst_pc, inst, inst_pcp4, exp_pc, memword(exp_pc), exp_p4);
      end
      g_acc = 1;
      g_acc_pc = inst_pc;
      g_acc_pcp4 = inst_pcp4;
      exp_pc = exp_pc + 30'd1;
      mfifo--;
    end
    if (imem_rvalid) e = mq.pop_front();
    if (rd) begin
      foreach (mq[i]) mq[i].stale = 1;
      mfifo = 0;
      exp_pc = rpc;
      exp_fetch = rpc;
    end else begin
      if (imem_rvalid && !e.stale) mfifo++;
      if (imem_req && gnt) begin
        checks++;
        if (imem_addr !== exp_fetch) begin
          errors++;
          $display("FAIL imem_addr: got %h want %h", imem_addr, exp_fetch);
        end
        g_gnt = 1;
        g_gnt_addr = imem_addr;
        mq.push_back('{addr: imem_addr, stale: 1'b0});
        exp_fetch = exp_fetch + 30'd1;
      end
    end
    @(posedge clk);
  endtask

  task automatic do_reset();
    step(1, 0, '0, 0, 0, 0);
    step(1, 0, '0, 0, 0, 0);
  endtask

  task automatic test_reset();
    step(1, 0, '0, 1, 1, 1);
    step(1, 0, '0, 1, 1, 1);
    checks++;
    if (s_addr !== 30'h0C00) begin
      errors++;
      $display("FAIL reset_addr: got %h want 00000c00", s_addr);
    end
    step(0, 0, '0, 1, 1, 1);
    checks++;
    if (s_req !== 1'b0 || s_ival !== 1'b0) begin
      errors++;
      $display("FAIL post_reset: got req %b valid %b want 0 0", s_req, s_ival);
    end
  endtask

  task automatic test_sequential();
    logic [29:0] ga[$];
    logic [29:0] aa[$];
    logic [31:0] ap4[$];
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(0, 0, '0, 1, 1, 1);
      if (g_gnt) ga.push_back(g_gnt_addr);
      if (g_acc) begin
        aa.push_back(g_acc_pc);
        ap4.push_back(g_acc_pcp4);
      end
    end
    checks++;
    if (ga.size() < 2 || ga[0] !== 30'h0C00 || ga[1] !== 30'h0C01) begin
      errors++;
      $display("FAIL seq_grants: got %0d grants first %h want 00000c00,00000c01",
               ga.size(), ga.size() > 0 ? ga[0] : 30'h0);
    end
    checks++;
    if (aa.size() < 2 || aa[0] !== 30'h0C00 || aa[1] !== 30'h0C01 ||
        ap4[0] !== 32'h0000_3004) begin
      errors++;
      $display("FAIL seq_accepts: got %0d accepts want pc 0c00,0c01 p4 3004",
               aa.size());
    end
  endtask

  task automatic test_stall();
    int ng = 0;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(0, 0, '0, 1, 1, 0);
      if (g_gnt) ng++;
    end
    checks++;
    if (ng != 2) begin
      errors++;
      $display("FAIL stall_grants: got %0d want 2", ng);
    end
    checks++;
    if (s_req !== 1'b0 || s_ival !== 1'b1 || s_ipc !== 30'h0C00) begin
      errors++;
      $display("FAIL stall_hold: got req %b valid %b pc %h want 0 1 00000c00",
               s_req, s_ival, s_ipc);
    end
    ng = 0;
    for (int i = 0; i < 6; i++) begin
      step(0, 0, '0, 1, 1, 1);
      if (g_gnt) ng++;
    end
    checks++;
    if (ng == 0) begin
      errors++;
      $display("FAIL stall_resume: got 0 grants want >0");
    end
  endtask

  task automatic test_redirect();
    bit found = 0;
    logic [29:0] first = '0;
    do_reset();
    for (int i = 0; i < 4; i++) step(0, 0, '0, 1, 0, 1);
    checks++;
    if (mq.size() != 2) begin
      errors++;
      $display("FAIL redir_setup: got %0d outstanding want 2", mq.size());
    end
    step(0, 1, 30'h0100, 1, 0, 1);
    step(0, 0, '0, 1, 1, 1);
    checks++;
    if (s_ival !== 1'b0) begin
      errors++;
      $display("FAIL redir_empty: got valid %b want 0", s_ival);
    end
    for (int i = 0; i < 20 && !found; i++) begin
      step(0, 0, '0, 1, 1, 1);
      if (g_acc) begin
        found = 1;
        first = g_acc_pc;
      end
    end
    checks++;
    if (!found || first !== 30'h0100) begin
      errors++;
      $display("FAIL redir_first: got found %b pc %h want 1 00000100", found, first);
    end
  endtask

  task automatic test_redir_collision();
    bit found = 0;
    logic [29:0] first = '0;
    do_reset();
    step(0, 0, '0, 1, 1, 0);
    step(0, 0, '0, 1, 1, 0);
    step(0, 0, '0, 1, 1, 0);
    step(0, 1, 30'h2345, 1, 1, 1);
    checks++;
    if (s_ival !== 1'b1 || s_req !== 1'b0 || !g_acc ||
        g_acc_pc !== 30'h0C00) begin
      errors++;
      $display("FAIL collide: got valid %b req %b pop %b pc %h want 1 0 1 00000c00",
               s_ival, s_req, g_acc, g_acc_pc);
    end
    for (int i = 0; i < 20 && !found; i++) begin
      step(0, 0, '0, 1, 1, 1);
      if (g_acc) begin
        found = 1;
        first = g_acc_pc;
      end
    end
    checks++;
    if (!found || first !== 30'h2345) begin
      errors++;
      $display("FAIL collide_first: got found %b pc %h want 1 00002345", found, first);
    end
  endtask

  task automatic test_wrap();
    logic [29:0] aa[$];
    logic [31:0] ap4[$];
    do_reset();
    step(0, 1, 30'h3FFF_FFFF, 1, 1, 1);
    for (int i = 0; i < 20 && aa.size() < 2; i++) begin
      step(0, 0, '0, 1, 1, 1);
      if (g_acc) begin
        aa.push_back(g_acc_pc);
        ap4.push_back(g_acc_pcp4);
      end
    end
    checks++;
    if (aa.size() < 2 || aa[0] !== 30'h3FFF_FFFF || aa[1] !== 30'h0 ||
        ap4[0] !== 32'h0) begin
      errors++;
      $display("FAIL wrap: got %0d accepts want pc 3fffffff,0 p4 0", aa.size());
    end
  endtask

  task automatic test_mid_reset();
    bit found = 0;
    logic [29:0] first = '0;
    do_reset();
    for (int i = 0; i < 8; i++) step(0, 0, '0, 1, 1, 0);
    checks++;
    if (s_ival !== 1'b1 || mfifo != DEPTH) begin
      errors++;
      $display("FAIL full_setup: got valid %b model fill %0d want 1 %0d",
               s_ival, mfifo, DEPTH);
    end
    step(1, 0, '0, 1, 0, 1);
    step(0, 0, '0, 1, 1, 1);
    checks++;
    if (s_ival !== 1'b0 || s_req !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got valid %b req %b want 0 0", s_ival, s_req);
    end
    for (int i = 0; i < 5 && !found; i++) begin
      step(0, 0, '0, 1, 1, 1);
      if (g_gnt) begin
        found = 1;
        first = g_gnt_addr;
      end
    end
    checks++;
    if (!found || first !== 30'h0C00) begin
      errors++;
      $display("FAIL restart: got found %b addr %h want 1 00000c00", found, first);
    end
  endtask

  task automatic test_random();
    int          nacc = 0;
    bit          r, rd, gnt, rv, rdy;
    logic [29:0] rpc;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      r   = ($urandom_range(0, 299) == 0);
      rd  = ($urandom_range(0, 19) == 0);
      rpc = ($urandom_range(0, 3) == 0) ?
            30'(32'h3FFF_FFFE + $urandom_range(0, 1)) : 30'($urandom);
      gnt = ($urandom_range(0, 3) != 0);
      rv  = ($urandom_range(0, 2) != 0);
      rdy = ($urandom_range(0, 3) != 0);
      step(r, rd, rpc, gnt, rv, rdy);
      if (g_acc) nacc++;
    end
    checks++;
    if (nacc < 500) begin
      errors++;
      $display("FAIL random_progress: got %0d accepts want >=500", nacc);
    end
  endtask

  initial begin
    mfifo = 0;
    exp_pc = 30'h0C00;
    exp_fetch = 30'h0C00;
    post_rst = 1;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_redir_collision();
    test_wrap();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
